mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit for the barrel pipeline.
- Sits directly downstream of the EX/MEM pipeline register and feeds the MEM/WB register.
- Issues data-memory requests with a req/ready handshake and generates byte enables and store-data lane replication.
- Sign/zero-extends load data, detects misaligned or illegal accesses, and stalls the pipeline while a bus access is outstanding, with a timeout.

Parameters:
- ADDRESS_WIDTH, 32, address and PC width.
- DATA_WIDTH, 32, data width; only 32 is supported.
- BITS_THREADS, 3, thread-id width.
- TIMEOUT_CYCLES, 16, maximum WAIT cycles before the access is abandoned with a bus error.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush_i  in  1  kill the instruction currently in MEM
- reg_write_m_i, mem_write_m_i  in  1 each  control signals from the EX/MEM register
- result_src_m_i  in  2  source select; 01 = load
- funct3_m_i  in  3  access size and signedness
- alu_result_m_i  in  ADDRESS_WIDTH  effective address
- write_data_m_i  in  DATA_WIDTH  store data
- rd_m_i  in  5  destination register
- pc_plus4_m_i  in  ADDRESS_WIDTH  PC + 4
- tid_m_i  in  BITS_THREADS  thread id
- dmem_req_o, dmem_we_o  out  1 each  bus request and write enable
- dmem_addr_o  out  ADDRESS_WIDTH  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata_o  out  DATA_WIDTH  lane-replicated store data
- dmem_be_o  out  4  byte enables
- dmem_ready_i  in  1  bus completion
- dmem_rdata_i  in  DATA_WIDTH  read data
- stall_m_o  out  1  drives the upstream register enables (1 = hold)
- reg_write_m_o  out  1  qualified write enable to MEM/WB
- result_src_m_o  out  2  pass-through
- alu_result_m_o, pc_plus4_m_o  out  widths as inputs  pass-through
- rd_m_o, tid_m_o  out  widths as inputs  pass-through
- read_data_m_o  out  DATA_WIDTH  extended load data
- misalign_m_o, bus_err_m_o  out  1 each  exception flags, pulsed for one completion cycle

Behaviour:
- **Access classification.** access = mem_write_m_i | (result_src_m_i == 01).
- **Illegal / misaligned.** An access is illegal when any of these hold:
  - funct3 is not in {000, 001, 010, 100, 101};
  - a store uses funct3 of 100 or 101;
  - a half-word access has addr[0] = 1;
  - a word access has addr[1:0] != 0.
- **Illegal access handling.** No bus request is issued. misalign_m_o = 1 and reg_write_m_o = 0 in the same cycle. No stall.
- **State machine.** Two states, IDLE and WAIT, plus a wait counter (cnt, log2 TIMEOUT_CYCLES + 1 bits) and a kill flag.
- **Request issue.**
  - dmem_req_o = legal access, in IDLE or WAIT.
  - All dmem_* outputs are combinational from the held inputs.
  - While req is high, the request must stay stable until ready or timeout, because the upstream register is held by the stall.
- **IDLE transitions.**
  - Legal access with ready = 1: zero-wait completion. No stall; stay in IDLE.
  - Legal access with ready = 0: stall_m_o = 1; go to WAIT with cnt = 1.
- **WAIT transitions.**
  - stall_m_o = ~ready.
  - cnt increments each cycle while ready = 0.
  - ready = 1: complete, go to IDLE, clear cnt and kill.
  - cnt == TIMEOUT_CYCLES with ready = 0: drop req and stall. bus_err_m_o = 1 and reg_write_m_o = 0 that cycle; go to IDLE.
  - If ready and timeout coincide, ready wins.
- **Stores.** Byte enables by size and addr[1:0]:
  - SB: 4'b0001 << addr[1:0], wdata = {4{byte}}.
  - SH: 4'b0011 << addr[1:0], wdata = {2{half}}.
  - SW: 4'b1111, wdata = data.
  - dmem_we_o = mem_write_m_i.
- **Loads.** dmem_be_o = 4'b1111. The addressed lane of dmem_rdata_i is selected by addr[1:0], then:
  - LB and LH are sign-extended.
  - LBU and LHU are zero-extended.
  - LW is passed through.
  - read_data_m_o is valid in the completion cycle only; otherwise it is 0.
- **Non-memory instructions.** Pass through combinationally with no stall. reg_write_m_o = reg_write_m_i & ~flush_i.
- **Flush.**
  - Flush in IDLE with no pending access: reg_write_m_o = 0.
  - Flush during WAIT or a stalled IDLE: set kill. The bus transaction is not abandoned; the stall persists until ready. On completion reg_write_m_o = 0 and no exception flags are raised.
- **reg_write_m_o qualification.** reg_write_m_o = reg_write_m_i & completion-or-non-memory & ~illegal & ~kill & ~flush_i & ~bus_err.
- **Reset.** While rst = 1, force dmem_req_o, stall_m_o, reg_write_m_o, misalign_m_o and bus_err_m_o to 0, and read_data_m_o to 0. Next state is IDLE; cnt = 0; kill = 0.
- **Reset mid-WAIT.** Reset abandons the access; the bus owner resets with the same rst.

Test Plan:
- LW addr 0x100, ready = 1 immediately, rdata 0xDEADBEEF -> no stall; read_data 0xDEADBEEF; reg_write 1; req high for exactly one cycle.
- LB addr 0x103, rdata 0x80_00_00_00, ready after 3 cycles -> stall 1 for 3 cycles; read_data 0xFFFFFF80. Repeated as LBU -> read_data 0x00000080.
- SH addr 0x202, data 0x1234ABCD -> be 4'b1100; wdata 0xABCDABCD; we 1. SH addr 0x201 -> no req; misalign 1; reg_write 0.
- Load with ready never asserted, TIMEOUT_CYCLES = 16 -> stall high for 16 cycles, then bus_err pulse, reg_write 0, state IDLE, and the next instruction proceeds.
- Flush asserted in the second WAIT cycle of an LW, ready in the fifth cycle -> req held until ready; reg_write 0 at completion; no flags raised.
- rst asserted during WAIT -> next cycle req 0, stall 0, state IDLE; a subsequent LHU addr 0x6 with rdata 0xBEEF0000 -> read_data 0x0000BEEF.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-stage load/store unit for the barrel pipeline.
// Byte-lane steering, load extension, and bus wait with timeout.
module mem_stage_lsu #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BITS_THREADS   = 3,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     reg_write_m_i,
  input  logic                     mem_write_m_i,
  input  logic [1:0]               result_src_m_i,
  input  logic [2:0]               funct3_m_i,
  input  logic [ADDRESS_WIDTH-1:0] alu_result_m_i,
  input  logic [DATA_WIDTH-1:0]    write_data_m_i,
  input  logic [4:0]               rd_m_i,
  input  logic [ADDRESS_WIDTH-1:0] pc_plus4_m_i,
  input  logic [BITS_THREADS-1:0]  tid_m_i,
  output logic                     dmem_req_o,
  output logic                     dmem_we_o,
  output logic [ADDRESS_WIDTH-1:0] dmem_addr_o,
  output logic [DATA_WIDTH-1:0]    dmem_wdata_o,
  output logic [3:0]               dmem_be_o,
  input  logic                     dmem_ready_i,
  input  logic [DATA_WIDTH-1:0]    dmem_rdata_i,
  output logic                     stall_m_o,
  output logic                     reg_write_m_o,
  output logic [1:0]               result_src_m_o,
  output logic [ADDRESS_WIDTH-1:0] alu_result_m_o,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_m_o,
  output logic [4:0]               rd_m_o,
  output logic [BITS_THREADS-1:0]  tid_m_o,
  output logic [DATA_WIDTH-1:0]    read_data_m_o,
  output logic                     misalign_m_o,
  output logic                     bus_err_m_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          kill_q, kill_d;

  logic       is_load, access;
  logic       f3_ok, is_half, is_word;
  logic       illegal, legal;
  logic       timeout, done, stall;
  logic [1:0] off;

  logic [15:0]           lane;
  logic [DATA_WIDTH-1:0] load_ext;
  logic [3:0]            st_be;
  logic [DATA_WIDTH-1:0] st_data;

  assign off     = alu_result_m_i[1:0];
  assign is_load = result_src_m_i == 2'b01;
  assign access  = mem_write_m_i | is_load;

  // Decode funct3 into legality and access size
  always_comb begin
    f3_ok   = 1'b1;
    is_half = 1'b0;
    is_word = 1'b0;
    unique case (funct3_m_i)
      3'b000, 3'b100: f3_ok = 1'b1;
      3'b001, 3'b101: is_half = 1'b1;
      3'b010:         is_word = 1'b1;
      default:        f3_ok = 1'b0;
    endcase
  end

  assign illegal = access & (~f3_ok
                 | (mem_write_m_i & funct3_m_i[2])
                 | (is_half & off[0])
                 | (is_word & (|off)));
  assign legal   = access & ~illegal;

  // Ready beats timeout when both land in the same cycle.
  assign timeout = (state_q == WAIT)
                 & (cnt_q == CNT_MAX)
                 & ~dmem_ready_i;
  assign done    = legal & dmem_ready_i;
  assign stall   = legal & ~dmem_ready_i & ~timeout;

  // Next state: stay in WAIT while stalled, else return to IDLE
  always_comb begin
    state_d = IDLE;
    cnt_d   = '0;
    kill_d  = 1'b0;
    if (stall) begin
      state_d = WAIT;
      cnt_d   = cnt_q + 1'b1;
      kill_d  = kill_q | flush_i;
    end
  end

  // State, wait counter and kill flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kill_q  <= kill_d;
    end
  end

  // Store byte enables and lane replication
  always_comb begin
    st_be   = 4'b1111;
    st_data = write_data_m_i;
    unique case (1'b1)
      is_word: begin
        st_be   = 4'b1111;
        st_data = write_data_m_i;
      end
      is_half: begin
        st_be   = 4'b0011 << off;
        st_data = {2{write_data_m_i[15:0]}};
      end
      default: begin
        st_be   = 4'b0001 << off;
        st_data = {4{write_data_m_i[7:0]}};
      end
    endcase
  end

  assign lane = 16'(dmem_rdata_i >> {off, 3'b000});

  // Load lane select and sign/zero extension
  always_comb begin
    load_ext = dmem_rdata_i;
    unique case (funct3_m_i)
      3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_ext = {{16{lane[15]}}, lane};
      3'b100:  load_ext = {24'd0, lane[7:0]};
      3'b101:  load_ext = {16'd0, lane};
      default: load_ext = dmem_rdata_i;
    endcase
  end

  assign dmem_req_o   = legal & ~timeout & ~rst;
  assign dmem_we_o    = mem_write_m_i;
  assign dmem_addr_o  = {alu_result_m_i[ADDRESS_WIDTH-1:2], 2'b00};
  assign dmem_wdata_o = st_data;
  assign dmem_be_o    = mem_write_m_i ? st_be : 4'b1111;

  assign stall_m_o     = stall & ~rst;
  assign misalign_m_o  = illegal & ~flush_i & ~rst;
  assign bus_err_m_o   = timeout & ~kill_q & ~flush_i & ~rst;
  assign reg_write_m_o = reg_write_m_i & (done | ~access)
                       & ~illegal & ~kill_q & ~flush_i
                       & ~timeout & ~rst;
  assign read_data_m_o = (done & ~rst) ? load_ext : '0;

  assign result_src_m_o = result_src_m_i;
  assign alu_result_m_o = alu_result_m_i;
  assign pc_plus4_m_o   = pc_plus4_m_i;
  assign rd_m_o         = rd_m_i;
  assign tid_m_o        = tid_m_i;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed bench for mem_stage_lsu.
// Per-cycle model compare plus literal expectations.
module tb_mem_stage_lsu;

  localparam int TO = 16;

  logic        clk, rst, flush, rw, mwe;
  logic [1:0]  src;
  logic [2:0]  f3;
  logic [31:0] addr, wd, pc, rdata;
  logic [4:0]  rd;
  logic [2:0]  tid;
  logic        rdy;

  logic        dmem_req_o, dmem_we_o, stall_m_o, reg_write_m_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic [1:0]  result_src_m_o;
  logic [31:0] alu_result_m_o, pc_plus4_m_o, read_data_m_o;
  logic [4:0]  rd_m_o;
  logic [2:0]  tid_m_o;
  logic        misalign_m_o, bus_err_m_o;

  int vec = 0;
  int miss = 0;
  bit run = 0;
  int m_age = 0;
  bit m_kill = 0;
  int stalls;

  mem_stage_lsu #(
    .ADDRESS_WIDTH(32), .DATA_WIDTH(32),
    .BITS_THREADS(3), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .flush_i(flush),
    .reg_write_m_i(rw), .mem_write_m_i(mwe),
    .result_src_m_i(src), .funct3_m_i(f3),
    .alu_result_m_i(addr), .write_data_m_i(wd),
    .rd_m_i(rd), .pc_plus4_m_i(pc), .tid_m_i(tid),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_be_o(dmem_be_o), .dmem_ready_i(rdy),
    .dmem_rdata_i(rdata), .stall_m_o(stall_m_o),
    .reg_write_m_o(reg_write_m_o),
    .result_src_m_o(result_src_m_o),
    .alu_result_m_o(alu_result_m_o),
    .pc_plus4_m_o(pc_plus4_m_o), .rd_m_o(rd_m_o),
    .tid_m_o(tid_m_o), .read_data_m_o(read_data_m_o),
    .misalign_m_o(misalign_m_o), .bus_err_m_o(bus_err_m_o)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic bit f_acc(bit mw, logic [1:0] s);
    return mw || s == 2'b01;
  endfunction

  function automatic bit f_ill(bit mw, logic [1:0] s,
                               logic [2:0] f, logic [31:0] a);
    bit ok;
    int n;
    ok = (f == 0 || f == 1 || f == 2 || f == 4 || f == 5);
    n = 1 << f[1:0];
    return f_acc(mw, s) && (!ok || (mw && f >= 4) || (a % n != 0));
  endfunction

  function automatic logic [31:0] f_load(logic [2:0] f,
                                         logic [31:0] a,
                                         logic [31:0] d);
    logic [31:0] b, h;
    b = (d >> (8 * (a % 4))) & 32'hFF;
    h = (d >> (8 * (a % 4))) & 32'hFFFF;
    case (f)
      3'd0:    return b >= 128 ? b - 32'd256 : b;
      3'd1:    return h >= 32768 ? h - 32'd65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return d;
    endcase
  endfunction

  // Model: age of the outstanding access and whether it was flushed
  always @(posedge clk) begin
    bit lg;
    lg = f_acc(mwe, src) && !f_ill(mwe, src, f3, addr);
    if (rst) begin
      m_age = 0;
      m_kill = 0;
    end else if (lg && !rdy && m_age != TO) begin
      m_age++;
      m_kill = m_kill | flush;
    end else begin
      m_age = 0;
      m_kill = 0;
    end
  end

  // Compare DUT against the model every cycle
  always @(negedge clk) begin
    bit acc, ill, lg, tmo, dn;
    bit e_req, e_stall, e_rw, e_mis, e_berr;
    logic [31:0] e_rd, e_be, e_wd;
    int n;
    if (run) begin
      acc = f_acc(mwe, src);
      ill = f_ill(mwe, src, f3, addr);
      lg = acc && !ill;
      tmo = lg && !rdy && m_age == TO;
      dn = lg && rdy;
      e_req = lg && !tmo;
      e_stall = lg && !rdy && !tmo;
      e_mis = ill && !flush;
      e_berr = tmo && !m_kill && !flush;
      e_rw = rw && (dn || !acc) && !ill && !m_kill && !flush && !tmo;
      e_rd = dn ? f_load(f3, addr, rdata) : 32'd0;
      if (rst) begin
        e_req = 0; e_stall = 0; e_rw = 0;
        e_mis = 0; e_berr = 0; e_rd = 0;
      end
      chk("req", dmem_req_o, e_req);
      chk("stall", stall_m_o, e_stall);
      chk("reg_write", reg_write_m_o, e_rw);
      chk("misalign", misalign_m_o, e_mis);
      chk("bus_err", bus_err_m_o, e_berr);
      chk("read_data", read_data_m_o, e_rd);
      chk("pass_alu", alu_result_m_o, addr);
      chk("pass_pc", pc_plus4_m_o, pc);
      chk("pass_misc", {result_src_m_o, rd_m_o, tid_m_o},
          {src, rd, tid});
      if (e_req) begin
        n = 1 << f3[1:0];
        e_be = mwe ? (((1 << n) - 1) << (addr % 4)) & 32'hF
                   : 32'hF;
        e_wd = n == 1 ? (wd & 32'hFF) * 32'h01010101 :
               n == 2 ? (wd & 32'hFFFF) * 32'h00010001 : wd;
        chk("addr", dmem_addr_o, addr & ~32'd3);
        chk("we", dmem_we_o, mwe);
        chk("be", dmem_be_o, e_be);
        if (mwe) chk("wdata", dmem_wdata_o, e_wd);
      end
    end
  end

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input bit rw_, input bit mwe_,
                    input logic [1:0] s_, input logic [2:0] f_,
                    input logic [31:0] a_, input logic [31:0] d_);
    rw = rw_; mwe = mwe_; src = s_; f3 = f_;
    addr = a_; wd = d_;
    rd = 5'(a_ >> 2);
    pc = a_ + 32'h1000;
    tid = 3'(a_);
  endtask

  task automatic bus(input bit r_, input logic [31:0] d_);
    rdy = r_;
    rdata = d_;
  endtask

  task automatic nop();
    op(1, 0, 2'b00, 3'b000, 32'h1234, 32'h0);
    bus(0, 32'h0);
  endtask

  initial begin
    rst = 1; flush = 0;
    op(1, 0, 2'b01, 3'b010, 32'h100, 0);
    bus(0, 0);
    go();
    run = 1;
    #3;
    chk("rst_req", dmem_req_o, 0);
    chk("rst_stall", stall_m_o, 0);
    chk("rst_rw", reg_write_m_o, 0);

    go(); rst = 0; nop(); #3;
    chk("alu_rw", reg_write_m_o, 1);
    chk("alu_pass", alu_result_m_o, 32'h1234);

    go(); op(1, 0, 2'b01, 3'b010, 32'h100, 0);
    bus(1, 32'hDEADBEEF); #3;
    chk("lw_rd", read_data_m_o, 32'hDEADBEEF);
    chk("lw_rw", reg_write_m_o, 1);
    chk("lw_stall", stall_m_o, 0);
    chk("lw_req", dmem_req_o, 1);
    go(); nop(); #3;
    chk("lw_req_drop", dmem_req_o, 0);

    for (int i = 0; i < 4; i++) begin
      go(); op(1, 0, 2'b01, 3'b000, 32'h103, 0);
      bus(i == 3, 32'h80000000); #3;
      if (i < 3) chk("lb_stall", stall_m_o, 1);
      else chk("lb_rd", read_data_m_o, 32'hFFFFFF80);
    end
    for (int i = 0; i < 4; i++) begin
      go(); op(1, 0, 2'b01, 3'b100, 32'h103, 0);
      bus(i == 3, 32'h80000000); #3;
      if (i == 3) chk("lbu_rd", read_data_m_o, 32'h00000080);
    end

    go(); op(0, 1, 2'b00, 3'b001, 32'h202, 32'h1234ABCD);
    bus(1, 0); #3;
    chk("sh_be", dmem_be_o, 4'b1100);
    chk("sh_wdata", dmem_wdata_o, 32'hABCDABCD);
    chk("sh_we", dmem_we_o, 1);
    go(); op(0, 1, 2'b00, 3'b001, 32'h201, 32'h1234ABCD); #3;
    chk("sh_mis_req", dmem_req_o, 0);
    chk("sh_mis", misalign_m_o, 1);
    go(); op(1, 0, 2'b01, 3'b010, 32'h102, 0); #3;
    chk("lw_mis", misalign_m_o, 1);
    chk("lw_mis_rw", reg_write_m_o, 0);

    stalls = 0;
    for (int i = 0; i <= TO; i++) begin
      go(); op(1, 0, 2'b01, 3'b010, 32'h300, 0);
      bus(0, 0); #3;
      stalls += int'(stall_m_o);
      if (i == TO) begin
        chk("to_berr", bus_err_m_o, 1);
        chk("to_rw", reg_write_m_o, 0);
        chk("to_req", dmem_req_o, 0);
      end
    end
    chk("to_stalls", stalls, TO);
    go(); nop(); #3;
    chk("after_to_rw", reg_write_m_o, 1);
    chk("after_to_stall", stall_m_o, 0);

    for (int i = 0; i < 5; i++) begin
      go(); op(1, 0, 2'b01, 3'b010, 32'h400, 0);
      flush = (i == 2);
      bus(i == 4, 32'h11223344); #3;
      chk("fl_req", dmem_req_o, 1);
      if (i == 4) begin
        chk("fl_rw", reg_write_m_o, 0);
        chk("fl_berr", bus_err_m_o, 0);
      end
    end
    go(); flush = 0; nop(); #3;

    go(); op(1, 0, 2'b01, 3'b010, 32'h500, 0); bus(0, 0);
    go();
    go(); rst = 1; #3;
    chk("rstw_req", dmem_req_o, 0);
    chk("rstw_stall", stall_m_o, 0);
    go(); rst = 0;
    op(1, 0, 2'b01, 3'b101, 32'h6, 0);
    bus(1, 32'hBEEF0000); #3;
    chk("lhu_rd", read_data_m_o, 32'h0000BEEF);
    chk("lhu_stall", stall_m_o, 0);

    go(); op(0, 1, 2'b00, 3'b000, 32'h11, 32'hA5); bus(1, 0); #3;
    chk("sb_be", dmem_be_o, 4'b0010);
    chk("sb_wdata", dmem_wdata_o, 32'hA5A5A5A5);
    go(); op(0, 1, 2'b00, 3'b010, 32'h20, 32'hCAFEF00D); #3;
    chk("sw_be", dmem_be_o, 4'b1111);
    chk("sw_wdata", dmem_wdata_o, 32'hCAFEF00D);
    go(); op(1, 0, 2'b01, 3'b001, 32'h2, 0);
    bus(1, 32'h80010000); #3;
    chk("lh_rd", read_data_m_o, 32'hFFFF8001);
    go(); op(1, 0, 2'b01, 3'b011, 32'h0, 0); #3;
    chk("f3_bad", misalign_m_o, 1);
    go(); op(0, 1, 2'b00, 3'b100, 32'h0, 0); #3;
    chk("st_f3_bad", misalign_m_o, 1);
    go(); op(1, 0, 2'b01, 3'b010, 32'h600, 0);
    flush = 1; #3;
    chk("fl0_rw", reg_write_m_o, 0);
    go(); op(1, 0, 2'b01, 3'b010, 32'h700, 0);
    bus(0, 0); #3;
    go(); flush = 0; bus(1, 32'h5); #3;
    chk("fl_idle_rw", reg_write_m_o, 0);
    go(); nop(); #3;
    go();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
